// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and its multiply/divide unit.
package alu_pkg;

   // Combinational ALU op select (alu_control)
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_PASA = 4'd10;
   localparam logic [3:0] ALU_PASB = 4'd11;
   localparam logic [3:0] ALU_ADD8 = 4'd12;

   // Multiply/divide op select (md_op); bit 0 set means unsigned
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up on magnitudes, and the HI/LO architectural registers.
module muldiv_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             md_busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_t            r_state, w_state_nxt;
   logic [SHAMT_W-1:0]   r_cnt;
   // Multiply: {partial sum, remaining multiplier}. Divide: {remainder, quotient/dividend}.
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mcand;    // multiplicand or divisor magnitude
   logic [WIDTH-1:0]     r_a_orig;   // original dividend for the divide-by-zero result
   logic [1:0]           r_op;
   logic                 r_neg_q;    // product/quotient must be negated
   logic                 r_neg_r;    // remainder must be negated (dividend sign)
   logic                 r_done;
   logic [WIDTH-1:0]     r_hi, r_lo;

   logic                 w_signed, w_a_neg, w_b_neg, w_is_div;
   logic [WIDTH-1:0]     w_a_mag, w_b_mag;
   logic [WIDTH:0]       w_mul_sum, w_rem_sh, w_rem_diff;
   logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_prod;
   logic [WIDTH-1:0]     w_fix_hi, w_fix_lo;

   function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign w_a_neg  = w_signed & operand_A[WIDTH-1];
   assign w_b_neg  = w_signed & operand_B[WIDTH-1];
   assign w_a_mag  = cond_neg(w_a_neg, operand_A);
   assign w_b_mag  = cond_neg(w_b_neg, operand_B);
   assign w_is_div = r_op[1];

   // One shift-add multiply step: add multiplicand if LSB set, then shift right.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

   // One restoring divide step: shift in next dividend bit, subtract if it fits.
   assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_rem_diff = w_rem_sh - {1'b0, r_mcand};
   assign w_div_nxt  = w_rem_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                         : {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = r_neg_q ? -r_acc : r_acc;

   // Final sign correction and divide-by-zero override for the HI/LO write.
   always_comb begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
      if (w_is_div) begin
         if (r_mcand == '0) begin
            w_fix_hi = r_a_orig;
            w_fix_lo = '1;
         end else begin
            w_fix_hi = cond_neg(r_neg_r, r_acc[2*WIDTH-1:WIDTH]);
            w_fix_lo = cond_neg(r_neg_q, r_acc[WIDTH-1:0]);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: IDLE -> RUN for WIDTH iterations -> FIX -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (md_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == SHAMT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, per-cycle iteration, and HI/LO write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_a_orig <= '0;
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (md_start) begin
                  r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mcand  <= w_b_mag;
                  r_a_orig <= operand_A;
                  r_op     <= md_op;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_cnt    <= '0;
               end else begin
                  if (hi_we) r_hi <= operand_A;
                  if (lo_we) r_lo <= operand_A;
               end
            end
            ST_RUN: begin
               r_acc <= w_is_div ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt + SHAMT_W'(1);
            end
            ST_FIX: begin
               r_hi   <= w_fix_hi;
               r_lo   <= w_fix_lo;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign md_busy = (r_state != ST_IDLE);
   assign md_done = r_done;
   assign hi      = r_hi;
   assign lo      = r_lo;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle combinational ops with Z/N/V flags, plus the
// iterative multiply/divide unit holding HI/LO.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] result,
   output logic             z_flag,
   output logic             n_flag,
   output logic             v_flag,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             md_busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [SHAMT_W-1:0]      w_shamt;
   logic signed [WIDTH-1:0] w_a_s, w_b_s;
   logic [WIDTH-1:0]        w_sum, w_diff;
   logic                    w_add_ovf, w_sub_ovf;

   assign w_shamt = operand_A[SHAMT_W-1:0];
   assign w_a_s   = operand_A;
   assign w_b_s   = operand_B;
   assign w_sum   = operand_A + operand_B;
   assign w_diff  = operand_A - operand_B;

   // Overflow: same-sign add flips sign; differing-sign subtract departs from A's sign.
   assign w_add_ovf = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) && (w_sum[WIDTH-1]  != operand_A[WIDTH-1]);
   assign w_sub_ovf = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) && (w_diff[WIDTH-1] != operand_A[WIDTH-1]);

   // Op decode and result mux; V is meaningful only for ADD/SUB.
   always_comb begin
      result = '0;
      v_flag = 1'b0;
      case (alu_control)
         ALU_ADD:  begin result = w_sum;  v_flag = w_add_ovf; end
         ALU_SUB:  begin result = w_diff; v_flag = w_sub_ovf; end
         ALU_AND:  result = operand_A & operand_B;
         ALU_OR:   result = operand_A | operand_B;
         ALU_XOR:  result = operand_A ^ operand_B;
         ALU_NOR:  result = ~(operand_A | operand_B);
         ALU_SLL:  result = operand_B << w_shamt;
         ALU_SRL:  result = operand_B >> w_shamt;
         ALU_SRA:  result = w_b_s >>> w_shamt;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
         ALU_PASA: result = operand_A;
         ALU_PASB: result = operand_B;
         ALU_ADD8: result = operand_B + WIDTH'(8);
         default:  result = '0;
      endcase
   end

   assign z_flag = (result == '0);
   assign n_flag = result[WIDTH-1];

   muldiv_unit #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .operand_A (operand_A),
      .operand_B (operand_B),
      .md_start  (md_start),
      .md_op     (md_op),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .md_busy   (md_busy),
      .md_done   (md_done),
      .hi        (hi),
      .lo        (lo)
   );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: combinational ALU vectors and a
// scoreboard of expected HI/LO results for multiply/divide operations.
module tb_alu_muldiv;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  operand_A = '0;
   logic [W-1:0]  operand_B = '0;
   logic [3:0]    alu_control = '0;
   logic [W-1:0]  result;
   logic          z_flag, n_flag, v_flag;
   logic          md_start = 1'b0;
   logic [1:0]    md_op = '0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic          md_busy, md_done;
   logic [W-1:0]  hi, lo;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } md_res_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         z;
      logic         n;
      logic         v;
   } alu_vec_t;

   md_res_t sb_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .operand_A   (operand_A),
      .operand_B   (operand_B),
      .alu_control (alu_control),
      .result      (result),
      .z_flag      (z_flag),
      .n_flag      (n_flag),
      .v_flag      (v_flag),
      .md_start    (md_start),
      .md_op       (md_op),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .hi          (hi),
      .lo          (lo)
   );

   // Reference model built on native 64-bit and signed 32-bit arithmetic.
   function automatic md_res_t md_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      md_res_t                 res;
      logic signed [2*W-1:0]   sp;
      logic [2*W-1:0]          up;
      logic signed [W-1:0]     sa, sb, sq, sr;
      sa = a;
      sb = b;
      case (op)
         MD_MULT: begin
            sp = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            res = sp;
         end
         MD_MULTU: begin
            up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            res = up;
         end
         MD_DIV: begin
            if (b == '0) begin
               res.hi = a; res.lo = '1;
            end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
               res.hi = '0; res.lo = a;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               res.hi = sr; res.lo = sq;
            end
         end
         default: begin
            if (b == '0) begin
               res.hi = a; res.lo = '1;
            end else begin
               res.hi = a % b; res.lo = a / b;
            end
         end
      endcase
      return res;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", md_busy); end
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", md_done); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
   endtask

   task automatic test_alu();
      alu_vec_t v[$];
      v.push_back('{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1});
      v.push_back('{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
      v.push_back('{ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1});
      v.push_back('{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1});
      v.push_back('{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0});
      v.push_back('{ALU_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0});
      v.push_back('{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0});
      v.push_back('{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
      v.push_back('{ALU_SLL,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_SLL,  32'h00000024, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b1, 1'b0});
      v.push_back('{ALU_SRA,  32'h00000004, 32'h70000000, 32'h07000000, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});
      v.push_back('{ALU_PASA, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0});
      v.push_back('{ALU_PASB, 32'h00000000, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0});
      v.push_back('{ALU_ADD8, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'h00000004, 1'b0, 1'b0, 1'b0});
      v.push_back('{4'd13,    32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
      v.push_back('{4'd15,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});
      foreach (v[i]) begin
         @(negedge clk);
         alu_control = v[i].op; operand_A = v[i].a; operand_B = v[i].b;
         #1;
         checks++; if (result !== v[i].r) begin errors++; $display("FAIL alu_result[%0d] op=%0d got %h want %h", i, v[i].op, result, v[i].r); end
         checks++; if (z_flag !== v[i].z) begin errors++; $display("FAIL alu_z[%0d] got %0b want %0b", i, z_flag, v[i].z); end
         checks++; if (n_flag !== v[i].n) begin errors++; $display("FAIL alu_n[%0d] got %0b want %0b", i, n_flag, v[i].n); end
         checks++; if (v_flag !== v[i].v) begin errors++; $display("FAIL alu_v[%0d] got %0b want %0b", i, v_flag, v[i].v); end
      end
   endtask

   task automatic write_hilo(input bit to_hi, input logic [W-1:0] val);
      @(negedge clk);
      operand_A = val; hi_we = to_hi; lo_we = !to_hi;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      checks++;
      if (to_hi && hi !== val) begin errors++; $display("FAIL mthi got %h want %h", hi, val); end
      else if (!to_hi && lo !== val) begin errors++; $display("FAIL mtlo got %h want %h", lo, val); end
   endtask

   // Start one op, optionally with hi_we alongside start or an ignored
   // start/hi_we/lo_we burst mid-run, then check latency and scoreboard.
   task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input md_res_t exp, input int inject_at, input bit we_with_start,
                         input logic [W-1:0] held_hi);
      int      cnt;
      md_res_t e;
      @(negedge clk);
      operand_A = a; operand_B = b; md_op = op; md_start = 1'b1; hi_we = we_with_start;
      sb_q.push_back(exp);
      @(negedge clk);
      md_start = 1'b0; hi_we = 1'b0;
      if (we_with_start) begin
         checks++; if (hi !== held_hi) begin errors++; $display("FAIL start_wins_hi got %h want %h", hi, held_hi); end
      end
      cnt = 0;
      while (md_busy === 1'b1 && cnt < W + 20) begin
         if (cnt == inject_at) begin
            md_start = 1'b1; md_op = MD_DIV; hi_we = 1'b1; lo_we = 1'b1;
            operand_A = 32'hDEADBEEF; operand_B = 32'h1;
         end else begin
            md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      md_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      checks++; if (cnt !== W + 1) begin errors++; $display("FAIL md_busy_cycles op=%0d got %0d want %0d", op, cnt, W + 1); end
      checks++;
      if (md_done !== 1'b1 || sb_q.size() == 0) begin
         errors++; $display("FAIL md_done op=%0d got %0b want 1", op, md_done);
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         checks++; if (hi !== e.hi) begin errors++; $display("FAIL md_hi op=%0d a=%h b=%h got %h want %h", op, a, b, hi, e.hi); end
         checks++; if (lo !== e.lo) begin errors++; $display("FAIL md_lo op=%0d a=%h b=%h got %h want %h", op, a, b, lo, e.lo); end
      end
      @(negedge clk);
      checks++; if (md_done !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL md_after done=%0b busy=%0b want 0 0", md_done, md_busy); end
   endtask

   task automatic test_directed();
      run_md(MD_MULT,  32'hFFFFFFFD, 32'h00000007, {32'hFFFFFFFF, 32'hFFFFFFEB}, -1, 1'b0, '0);
      run_md(MD_DIVU,  32'd100,      32'd7,        {32'd2,        32'd14},       -1, 1'b0, '0);
      run_md(MD_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, 1'b0, '0);
      run_md(MD_DIV,   32'd7,        32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, -1, 1'b0, '0);
      run_md(MD_DIVU,  32'd5,        32'd0,        {32'd5,        32'hFFFFFFFF}, -1, 1'b0, '0);
      run_md(MD_DIV,   32'hFFFFFFF7, 32'd0,        {32'hFFFFFFF7, 32'hFFFFFFFF}, -1, 1'b0, '0);
      run_md(MD_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, -1, 1'b0, '0);
      run_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, -1, 1'b0, '0);
      run_md(MD_MULT,  32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, -1, 1'b0, '0);
   endtask

   task automatic test_ignored_controls();
      run_md(MD_MULTU, 32'd3, 32'd4, {32'd0, 32'd12}, 5, 1'b0, '0);
      write_hilo(1'b1, 32'hAAAA5555);
      run_md(MD_MULTU, 32'd2, 32'd3, {32'd0, 32'd6}, -1, 1'b1, 32'hAAAA5555);
   endtask

   task automatic test_random();
      logic [1:0]   op;
      logic [W-1:0] a, b;
      for (int i = 0; i < 10; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i % 3 == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
         run_md(op, a, b, md_model(op, a, b), -1, 1'b0, '0);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      write_hilo(1'b1, 32'h11111111);
      write_hilo(1'b0, 32'h22222222);
      @(negedge clk);
      operand_A = 32'hFFFFFFF9; operand_B = 32'd2; md_op = MD_DIV; md_start = 1'b1;
      @(negedge clk);
      md_start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", md_busy); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL abort_hi got %h want 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL abort_lo got %h want 0", lo); end
      seen = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (md_done === 1'b1 || md_busy === 1'b1) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
      run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_directed();
      test_ignored_controls();
      test_random();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
